// File: rtl/common_pkg.sv
// Shared parameter-legality checks and width helpers.
`ifndef V
`define V(x) [(x)-1:0]
`endif
package common_pkg;

  function automatic bit check_param_pos(int v);
    return v >= 1;
  endfunction

  function automatic bit check_param_pos2exp(int v);
    return (v >= 1) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit check_param_range(int v, int lo, int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic bit check_param_2(int v);
    return (v == 0) || (v == 1);
  endfunction

  function automatic int cnt_w(int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/elastic_fifo_pkg.sv
// Default parameter values for elastic_fifo; behaviour is parameter-driven.
package elastic_fifo_pkg;

  localparam int DefW     = 32;
  localparam int DefDepth = 4;
  localparam int DefFwft  = 1;

endpackage

// File: rtl/elastic_fifo_mem.sv
// Depth x W flop array: one write port, one combinational read port.
`ifndef V
`define V(x) [(x)-1:0]
`endif
module fifo_mem
  import common_pkg::*;
#(
  parameter int W     = 32,
  parameter int Depth = 4,
  localparam int PW   = $clog2(Depth)
) (
  input  logic           clk,
  input  logic           we_i,
  input  logic [PW-1:0]  waddr_i,
  input  logic `V(W)     wdata_i,
  input  logic [PW-1:0]  raddr_i,
  output logic `V(W)     rdata_o
);

  logic `V(W) mem_q [Depth];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/elastic_fifo.sv
// Synchronous ready/valid FIFO with registered head, occupancy and sticky err.
`ifndef V
`define V(x) [(x)-1:0]
`endif
module elastic_fifo
  import common_pkg::*;
  import elastic_fifo_pkg::*;
#(
  parameter int W     = DefW,
  parameter int Depth = DefDepth,
  parameter int Afull = Depth - 1,
  parameter int Fwft  = DefFwft,
  localparam int CW   = cnt_w(Depth),
  localparam int PW   = $clog2(Depth)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_v,
  output logic                  in_rdy,
  input  logic `V(W)            in_data,
  output logic                  out_v,
  input  logic                  out_rdy,
  output logic `V(W)            out_data,
  output logic `V(cnt_w(Depth)) count,
  output logic                  afull,
  output logic                  err
);

  if (!check_param_pos(W)) begin : g_bad_w
    $error("elastic_fifo: W must be >= 1");
  end
  if (!check_param_pos2exp(Depth) || !check_param_range(Depth, 2, 1 << 30)) begin : g_bad_d
    $error("elastic_fifo: Depth must be a power of two >= 2");
  end
  if (!check_param_range(Afull, 1, Depth)) begin : g_bad_af
    $error("elastic_fifo: Afull out of range");
  end
  if (!check_param_2(Fwft)) begin : g_bad_fwft
    $error("elastic_fifo: Fwft must be 0 or 1");
  end

  localparam logic [CW-1:0] DepthC = CW'(Depth);
  localparam logic [CW-1:0] AfullC = CW'(Afull);
  localparam logic [CW-1:0] OneC   = CW'(1);

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic `V(W)    data_q, data_d, rdata;
  logic          err_q, err_d;
  logic          stall_q;
  logic `V(W)    sdata_q;
  logic          in_hs, out_hs;

  assign in_rdy   = count_q != DepthC;
  assign out_v    = count_q != '0;
  assign afull    = count_q >= AfullC;
  assign count    = count_q;
  assign out_data = data_q;
  assign err      = err_q;

  assign in_hs  = in_v && in_rdy;
  assign out_hs = out_v && out_rdy;

  fifo_mem #(.W(W), .Depth(Depth)) u_mem (
    .clk     (clk),
    .we_i    (in_hs && !flush),
    .waddr_i (wr_q),
    .wdata_i (in_data),
    .raddr_i (rd_q + PW'(1)),
    .rdata_o (rdata)
  );

  // Head register mirrors mem[rd]; the entry after it is read ahead on pop.
  always_comb begin
    count_d = count_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    data_d  = data_q;
    if (flush) begin
      count_d = '0;
      rd_d    = '0;
      wr_d    = '0;
    end else begin
      count_d = count_q + CW'(in_hs) - CW'(out_hs);
      if (in_hs) wr_d = wr_q + PW'(1);
      if (out_hs) rd_d = rd_q + PW'(1);
      if (in_hs && (count_q == '0 || (count_q == OneC && out_hs)))
        data_d = in_data;
      else if (out_hs && count_q > OneC)
        data_d = rdata;
    end
  end

  // Protocol monitor: data must hold while stalled; no pop request when empty.
  always_comb begin
    err_d = err_q;
    if (out_rdy && !out_v) err_d = 1'b1;
    if (stall_q && in_v && in_data != sdata_q) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      stall_q <= 1'b0;
      sdata_q <= '0;
    end else begin
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      stall_q <= in_v && !in_rdy;
      sdata_q <= in_data;
    end
  end

endmodule
